// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared bus layouts, widths, FSM states and error bits for mem_stage
package mem_pkg;

  localparam int EX_BUS_W        = 155;
  localparam int WB_BUS_W        = 123;
  localparam int ID_BUS_W        = 38;
  localparam int TIMEOUT_CYC_DEF = 255;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_MISALIGN = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } mem_state_e;

  // Field order is MSB first; the packed layout defines the bit offsets.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] st_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1_data;
  } ex_bus_t;

  typedef struct packed {
    logic [31:0] wb_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  err;
  } wb_bus_t;

  typedef struct packed {
    logic [31:0] fwd_data;
    logic        fwd_wen;
    logic [4:0]  fwd_rd;
  } id_bus_t;

endpackage

// File: rtl/mem_dmem_ctrl.sv
// rtl/mem_dmem_ctrl.sv - data-memory handshake FSM with watchdog counter and load-data capture
module mem_dmem_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memop,
  input  logic        is_store,
  input  logic        misalign,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err
);

  mem_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        expired;

  assign expired = (cnt_q == 16'(TIMEOUT_CYC));
  assign done    = (state_q == ST_DONE);
  assign rdata   = rdata_q;
  assign err     = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    dmem_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memop) begin
          cnt_d = '0;
          if (misalign) begin
            state_d               = ST_DONE;
            err_d[ERR_MISALIGN]   = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_gnt) state_d = is_store ? ST_DONE : ST_RESP;
            else          state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 16'd1;
        // Timeout wins over a coincident grant so the abort cycle never issues.
        if (expired) begin
          state_d            = ST_DONE;
          err_d[ERR_TIMEOUT] = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            state_d = is_store ? ST_DONE : ST_RESP;
            cnt_d   = '0;
          end
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (expired) begin
          state_d            = ST_DONE;
          err_d[ERR_TIMEOUT] = 1'b1;
        end else if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory stage: ex_r register, result mux and bus packing.
// Define MEM_MISALIGN_CHK_EN to trap misaligned accesses instead of dropping the low address bits.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [EX_BUS_W-1:0] exe_mem_bus_in,
  output logic                mem_stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [31:0]         dmem_rdata,
  output logic [WB_BUS_W-1:0] mem_wb_bus_out,
  output logic                mem_wb_valid,
  output logic [ID_BUS_W-1:0] mem_id_data_bus
);

  ex_bus_t     ex_q, ex_d;
  wb_bus_t     wb_bus;
  id_bus_t     id_bus;
  logic        memop, is_store, is_load, misalign, ctrl_done, rd_wen_eff;
  logic [31:0] ctrl_rdata, wb_result;
  logic [1:0]  ctrl_err, err;

  // A store takes priority when both access bits are set.
  assign is_store     = ex_q.mem_we;
  assign is_load      = ex_q.mem_re & ~ex_q.mem_we;
  assign memop        = ex_q.mem_we | ex_q.mem_re;
  assign mem_stall    = memop & ~ctrl_done;
  assign mem_wb_valid = ~mem_stall;

  always_comb begin
    ex_d = ex_q;
    if (!mem_stall) ex_d = exe_mem_bus_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = memop & (ex_q.alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  mem_dmem_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .memop      (memop),
    .is_store   (is_store),
    .misalign   (misalign),
    .dmem_gnt   (dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .done       (ctrl_done),
    .rdata      (ctrl_rdata),
    .err        (ctrl_err)
  );

  assign dmem_we    = is_store;
  assign dmem_addr  = {ex_q.alu_result[31:2], 2'b00};
  assign dmem_wdata = ex_q.st_data;

  always_comb begin
    err = ctrl_err;
`ifndef MEM_MISALIGN_CHK_EN
    err[ERR_MISALIGN] = 1'b0;
`endif
    wb_result  = is_load ? ctrl_rdata : ex_q.alu_result;
    rd_wen_eff = ex_q.rd_wen & ~(|err);

    wb_bus.wb_result = wb_result;
    wb_bus.rd        = ex_q.rd;
    wb_bus.rd_wen    = rd_wen_eff;
    wb_bus.wb_sel    = ex_q.wb_sel;
    wb_bus.pc        = ex_q.pc;
    wb_bus.csr_cmd   = ex_q.csr_cmd;
    wb_bus.csr_addr  = ex_q.csr_addr;
    wb_bus.csr_wdata = ex_q.op1_data;
    wb_bus.err       = err;

    // Decode must not forward a load result before the data has landed.
    id_bus.fwd_data = wb_result;
    id_bus.fwd_wen  = rd_wen_eff & ~(is_load & ~ctrl_done);
    id_bus.fwd_rd   = ex_q.rd;
  end

  assign mem_wb_bus_out  = wb_bus;
  assign mem_id_data_bus = id_bus;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with randomized memory latency
module tb_mem_stage;

  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [154:0] exe_mem_bus_in;
  logic         mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, mem_wb_valid;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [122:0] mem_wb_bus_out;
  logic [37:0]  mem_id_data_bus;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .exe_mem_bus_in (exe_mem_bus_in),
    .mem_stall      (mem_stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_wb_bus_out (mem_wb_bus_out),
    .mem_wb_valid   (mem_wb_valid),
    .mem_id_data_bus(mem_id_data_bus)
  );

  function automatic logic [154:0] mk_bus(input logic [31:0] alu, input logic [4:0] rd,
                                          input logic rd_wen, input logic we, input logic re,
                                          input logic [31:0] st);
    logic [2:0]  wb_sel = 3'($urandom);
    logic [31:0] pc     = $urandom;
    logic [3:0]  cmd    = 4'($urandom);
    logic [11:0] caddr  = 12'($urandom);
    logic [31:0] op1    = $urandom;
    return {alu, rd, rd_wen, we, re, wb_sel, pc, st, cmd, caddr, op1};
  endfunction

  // Plays one instruction through the stage. d_g: cycle in which gnt is offered;
  // d_r: RESP cycles before rvalid. Expected timeline comes from the latency rules.
  task automatic run_instr(input logic [154:0] bus, input int d_g, input int d_r,
                           input logic [31:0] rd_data, input string name);
    logic [31:0]  alu = bus[154:123];
    logic [4:0]   rd = bus[122:118];
    logic         rd_wen = bus[117];
    logic         we = bus[116];
    logic         re = bus[115];
    logic [31:0]  st = bus[79:48];
    logic         memop = we | re;
    logic         load = re & ~we;
    logic         mis = 1'b0;
    int           final_c, req_last, rv_c;
    bit           got_data = 0;
    logic [1:0]   err = 2'b00;
    logic         exp_req, wen_eff;
    logic [31:0]  wbr;
    logic [122:0] exp_wb;
    logic [37:0]  exp_id;
`ifdef MEM_MISALIGN_CHK_EN
    mis = memop & (alu[1:0] != 2'b00);
`endif
    rv_c = -1;
    if (!memop) begin
      final_c = 0; req_last = -1;
    end else if (mis) begin
      final_c = 1; req_last = -1; err = 2'b10;
    end else if (d_g > T) begin
      req_last = T; final_c = T + 2; err = 2'b01;
    end else begin
      req_last = d_g;
      if (!load) final_c = d_g + 1;
      else begin
        rv_c = d_g + 1 + d_r;
        if (d_r < T) begin final_c = d_g + 2 + d_r; got_data = 1; end
        else begin final_c = d_g + 2 + T; err = 2'b01; end
      end
    end

    exe_mem_bus_in = bus;
    @(posedge clk);
    for (int c = 0; c <= final_c; c++) begin
      @(negedge clk);
      if (memop && c == d_g) dmem_gnt = 1'b1;
      else dmem_gnt = (c > d_g) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == rv_c) begin
        dmem_rvalid = 1'b1; dmem_rdata = rd_data;
      end else begin
        dmem_rvalid = (!load || c <= d_g) ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rdata  = $urandom;
      end
      #1;
      exp_req = (c <= req_last);
      checks++;
      if (dmem_req !== exp_req) begin
        failures++;
        $display("FAIL %s req c=%0d got=%b exp=%b", name, c, dmem_req, exp_req);
      end
      checks++;
      if (mem_stall !== (c != final_c) || mem_wb_valid !== (c == final_c)) begin
        failures++;
        $display("FAIL %s stall c=%0d got=%b/%b exp_stall=%b", name, c, mem_stall,
                 mem_wb_valid, (c != final_c));
      end
      if (exp_req) begin
        checks++;
        if (dmem_addr !== {alu[31:2], 2'b00} || dmem_we !== we || dmem_wdata !== st) begin
          failures++;
          $display("FAIL %s reqfields c=%0d got=%h/%b/%h exp=%h/%b/%h", name, c, dmem_addr,
                   dmem_we, dmem_wdata, {alu[31:2], 2'b00}, we, st);
        end
      end
      if (load && c != final_c) begin
        checks++;
        if (mem_id_data_bus[5] !== 1'b0) begin
          failures++;
          $display("FAIL %s early_fwd c=%0d got=%b exp=0", name, c, mem_id_data_bus[5]);
        end
      end
      if (c == final_c) begin
        if (got_data) last_rdata = rd_data;
        wbr     = load ? last_rdata : alu;
        wen_eff = rd_wen & (err == 2'b00);
        exp_wb  = {wbr, rd, wen_eff, bus[114:112], bus[111:80], bus[47:44], bus[43:32],
                   bus[31:0], err};
        exp_id  = {wbr, wen_eff, rd};
        checks++;
        if (mem_wb_bus_out !== exp_wb) begin
          failures++;
          $display("FAIL %s wb_bus got=%h exp=%h", name, mem_wb_bus_out, exp_wb);
        end
        checks++;
        if (mem_id_data_bus !== exp_id) begin
          failures++;
          $display("FAIL %s id_bus got=%h exp=%h", name, mem_id_data_bus, exp_id);
        end
      end
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_wb_valid !== 1'b1 ||
        mem_wb_bus_out !== '0 || mem_id_data_bus !== '0 || dmem_addr !== '0 ||
        dmem_we !== 1'b0 || dmem_wdata !== '0) begin
      failures++;
      $display("FAIL %s req=%b stall=%b valid=%b wb=%h id=%h addr=%h we=%b wdata=%h exp all idle/zero",
               name, dmem_req, mem_stall, mem_wb_valid, mem_wb_bus_out, mem_id_data_bus,
               dmem_addr, dmem_we, dmem_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exe_mem_bus_in = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    last_rdata = '0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    run_instr(mk_bus(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0), 0, 0, 32'h0, "alu");
    run_instr(mk_bus($urandom, 5'd9, 1'b1, 1'b0, 1'b0, $urandom), 0, 0, 32'h0, "alu_b2b");
  endtask

  task automatic test_store();
    run_instr(mk_bus(32'h100, 5'd0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF), 0, 0, 32'h0, "store");
    run_instr(mk_bus(32'h104, 5'd3, 1'b1, 1'b1, 1'b1, 32'h0BADF00D), 1, 0, 32'h0, "store_both");
  endtask

  task automatic test_load();
    run_instr(mk_bus(32'h200, 5'd11, 1'b1, 1'b0, 1'b1, 32'h0), 2, 2, 32'hCAFEF00D, "load_slow");
    run_instr(mk_bus(32'h204, 5'd12, 1'b1, 1'b0, 1'b1, 32'h0), 0, 0, 32'h13572468, "load_fast");
  endtask

  task automatic test_timeout();
    run_instr(mk_bus(32'h300, 5'd7, 1'b1, 1'b0, 1'b1, 32'h0), 0, T, 32'h11111111, "to_rvalid_at_abort");
    run_instr(mk_bus(32'h304, 5'd8, 1'b1, 1'b0, 1'b1, 32'h0), 1, T + 1, 32'h22222222, "to_rvalid_late");
    run_instr(mk_bus(32'h308, 5'd9, 1'b1, 1'b1, 1'b0, 32'h5), T + 1, 0, 32'h0, "to_no_gnt");
    run_instr(mk_bus(32'h30C, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0), T, T - 1, 32'h33333333, "edge_ok");
  endtask

  task automatic test_misalign();
    run_instr(mk_bus(32'h103, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0), 0, 0, 32'h44444444, "misalign_load");
    run_instr(mk_bus(32'h102, 5'd6, 1'b1, 1'b1, 1'b0, 32'h77), 0, 0, 32'h0, "misalign_store");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 3);
      int dg = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(0, 3);
      int dr = $urandom_range(0, T + 1);
      run_instr(mk_bus($urandom, 5'($urandom), 1'($urandom), k[0], k[1], $urandom),
                dg, dr, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid_access(input bit in_resp);
    string nm = in_resp ? "rst_in_resp" : "rst_in_req";
    @(negedge clk);
    exe_mem_bus_in = mk_bus(32'h400, 5'd13, 1'b1, 1'b0, 1'b1, 32'h0);
    dmem_gnt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt = in_resp;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b1 || dmem_req !== !in_resp) begin
      failures++;
      $display("FAIL %s pre stall=%b req=%b exp 1/%b", nm, mem_stall, dmem_req, !in_resp);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs(nm);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b0;
    last_rdata = '0;
    run_instr(mk_bus(32'h500, 5'd14, 1'b1, 1'b0, 1'b1, 32'h0), 0, 1, 32'h600DCAFE, "after_rst");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_timeout();
    test_misalign();
    test_random();
    test_reset_mid_access(1'b0);
    test_reset_mid_access(1'b1);
    test_alu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. Registers the 155-bit execute-to-memory bus, runs word loads and stores against a handshaked data memory with a timeout watchdog, and stalls the upstream pipeline until each access completes. Drives the memory-to-writeback bus and the memory-stage forwarding bus back to decode.

## Interface
- TIMEOUT_CYC, 255: cycles in REQ+RESP before an access is aborted; range 1..65535.
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- exe_mem_bus_in  in  155  {alu_result[31:0], rd[4:0], rd_wen, mem_we, mem_re, wb_sel[2:0], pc[31:0], st_data[31:0], csr_cmd[3:0], csr_addr[11:0], op1_data[31:0]}, MSB first.
- mem_stall  out  1  freeze all upstream pipeline registers.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid; earliest one cycle after gnt.
- dmem_rdata  in  32  load data.
- mem_wb_bus_out  out  123  {wb_result[31:0], rd[4:0], rd_wen, wb_sel[2:0], pc[31:0], csr_cmd[3:0], csr_addr[11:0], csr_wdata[31:0], err[1:0]}.
- mem_wb_valid  out  1  mem_wb_bus_out is final this cycle.
- mem_id_data_bus  out  38  {fwd_data[31:0], fwd_wen, fwd_rd[4:0]}.

## Operation
- ex_r: 155-bit register. Loads exe_mem_bus_in every edge where mem_stall=0; holds when mem_stall=1. An all-zero bus is a NOP.
- memop = mem_we | mem_re, taken from ex_r. If both bits are set, the access is a store.
- State machine: IDLE, REQ, RESP, DONE.
  - IDLE: if no memop, pass the instruction through. If memop, assert dmem_req.
    - gnt received: store goes to DONE; load goes to RESP.
    - no gnt: go to REQ.
  - REQ: hold dmem_req, addr, we and wdata stable until gnt, then take the same transitions as IDLE.
  - RESP: wait for dmem_rvalid. Capture dmem_rdata into rdata_r, then go to DONE.
  - DONE: result final. Go to IDLE; ex_r loads the next instruction on the same edge.
- dmem_rvalid is ignored in every state except RESP. gnt is ignored outside IDLE/REQ.
- mem_stall = memop & (state != DONE), combinational.
- mem_wb_valid = ~mem_stall.
- Watchdog counter:
  - Clears on entry to REQ or RESP; increments each cycle in those states.
  - At count == TIMEOUT_CYC: drop dmem_req, go to DONE, set err[0].
  - err[0] forces rd_wen and fwd_wen to 0.
- wb_result = rdata_r for loads, otherwise alu_result.
- csr_wdata = op1_data. wb_sel, pc, csr_cmd and csr_addr pass through unchanged.
- Forwarding bus: fwd_data = wb_result, fwd_rd = rd. fwd_wen = rd_wen, gated to 0 while a load is not in DONE.
- dmem_addr = {alu_result[31:2], 2'b00}. dmem_wdata = st_data.

## Timing
- Non-memory instruction: zero added latency; output valid in the cycle after ex_r loads.
- Store: minimum 2 cycles in stage (IDLE with gnt, then DONE).
- Load: minimum 3 cycles (IDLE with gnt, RESP with rvalid, then DONE).
- Each extra gnt or rvalid wait cycle adds one cycle.
- Reset values: ex_r=0, state=IDLE, counter=0, rdata_r=0. All outputs follow from these: dmem_req=0, mem_stall=0, mem_wb_valid=1, all bus outputs 0.
- Reset mid-access drops dmem_req immediately (asynchronous). Any in-flight response is lost.

## Configuration
- MEM_MISALIGN_CHK_EN defined:
  - memop with alu_result[1:0] != 0 issues no request.
  - Goes IDLE -> DONE (1 stall cycle), sets err[1], forces rd_wen and fwd_wen to 0.
- MEM_MISALIGN_CHK_EN undefined:
  - Low address bits are silently dropped; err[1] is tied to 0.

## Structure
- Shared package mem_pkg holds:
  - bus widths (155, 123, 38) and field offsets;
  - the state enum;
  - err bit positions;
  - the TIMEOUT_CYC default.
- One sub-module, mem_dmem_ctrl, holds the state machine, watchdog counter and rdata_r capture. mem_stage itself holds ex_r, the result mux and the bus packing.

## Test plan
- ALU op, alu_result=0x1234, rd=5, rd_wen=1 -> same cycle: mem_stall=0, wb_result=0x1234, fwd_wen=1, fwd_rd=5.
- Store, addr=0x100, st_data=0xDEADBEEF, gnt in first cycle -> dmem_req high 1 cycle, we=1, wdata=0xDEADBEEF, mem_stall high exactly 1 cycle.
- Load, addr=0x200, gnt delayed 2 cycles, rvalid 3 cycles later with 0xCAFEF00D -> wb_result=0xCAFEF00D, fwd_wen=0 until DONE, upstream frozen throughout.
- TIMEOUT_CYC=4, load with no rvalid -> abort after 4 RESP cycles, err[0]=1, rd_wen=0. A late rvalid is ignored.
- MEM_MISALIGN_CHK_EN defined, load at addr=0x103 -> no dmem_req, err[1]=1, 1 stall cycle. Undefined -> dmem_addr=0x100, err[1]=0.
- rst asserted in RESP -> dmem_req=0 and mem_stall=0 immediately, state=IDLE. After release the next bus is accepted normally.
